// File: rtl/instr_reader.sv
// Read-side sequencer for the instruction register: sweeps a wrapping address range, streams
// each captured word on a valid/ready port and flags words whose stored result is inconsistent.
module instr_reader #(
   parameter int unsigned DEPTH    = 32,
   parameter bit          CHECK_EN = 1'b1,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned IW      = 100
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [5:0]    count,
   output logic [AW-1:0] read_pointer,
   input  logic [IW-1:0] instruction_word,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_word,
   output logic [5:0]    out_index,
   output logic          out_mismatch,
   output logic          busy,
   output logic          done,
   output logic [5:0]    err_count
);

   // Word layout: {opc[3:0], op_a[15:0], op_b[15:0], result[63:0]}, operands signed.
   localparam logic [3:0] OpZero  = 4'd0;
   localparam logic [3:0] OpPassA = 4'd1;
   localparam logic [3:0] OpPassB = 4'd2;
   localparam logic [3:0] OpAdd   = 4'd3;
   localparam logic [3:0] OpSub   = 4'd4;
   localparam logic [3:0] OpMult  = 4'd5;
   localparam logic [3:0] OpDiv   = 4'd6;
   localparam logic [3:0] OpMod   = 4'd7;
   localparam logic [3:0] OpPow   = 4'd8;

   typedef enum logic [1:0] {StIdle, StRead, StOut, StDone} state_e;

   state_e             state_q;
   logic [5:0]         remaining_q;
   logic [5:0]         count_clamped;
   logic [3:0]         opc;
   logic signed [63:0] a64;
   logic signed [63:0] b64;
   logic signed [63:0] stored;
   logic signed [63:0] expected;
   logic               mismatch;

   assign count_clamped = (count > 6'd32) ? 6'd32 : count;

   always_comb begin
      opc      = instruction_word[99:96];
      a64      = {{48{instruction_word[95]}}, instruction_word[95:80]};
      b64      = {{48{instruction_word[79]}}, instruction_word[79:64]};
      stored   = instruction_word[63:0];
      expected = 64'sd0;
      case (opc)
         OpZero:  expected = 64'sd0;
         OpPassA: expected = a64;
         OpPassB: expected = b64;
         OpAdd:   expected = a64 + b64;
         OpSub:   expected = a64 - b64;
         OpMult:  expected = a64 * b64;
         OpDiv:   expected = (b64 == 64'sd0) ? 64'sd0 : a64 / b64;
         OpMod:   expected = (b64 == 64'sd0) ? 64'sd0 : a64 % b64;
         OpPow:   expected = a64 ** b64;
         default: expected = 64'sd0;
      endcase
      mismatch = CHECK_EN && (stored != expected);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         read_pointer <= '0;
         out_valid    <= 1'b0;
         out_word     <= '0;
         out_index    <= '0;
         out_mismatch <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_count    <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  remaining_q <= count_clamped;
                  err_count   <= '0;
                  out_index   <= '0;
                  busy        <= 1'b1;
                  if (count_clamped == 6'd0) begin
                     state_q <= StDone;
                  end else begin
                     state_q      <= StRead;
                     read_pointer <= start_addr;
                  end
               end
            end
            StRead: begin
               out_word     <= instruction_word;
               out_mismatch <= mismatch;
               out_valid    <= 1'b1;
               state_q      <= StOut;
            end
            StOut: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  out_index   <= out_index + 6'd1;
                  remaining_q <= remaining_q - 6'd1;
                  if (CHECK_EN && out_mismatch && err_count != 6'd63) begin
                     err_count <= err_count + 6'd1;
                  end
                  if (remaining_q == 6'd1) begin
                     state_q <= StDone;
                  end else begin
                     state_q <= StRead;
                     // Natural wrap: DEPTH is a power of two matching the pointer width.
                     read_pointer <= read_pointer + AW'(1);
                  end
               end
            end
            StDone: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
